// File: rtl/mem_router_pkg.sv
// Shared types and constants for the memory channel router.
// Holds the in-order tracking entry and counter width.
package mem_router_pkg;

    // Channel index field, wide enough for the largest (8-channel) build
    localparam int CH_SEL_W = 3;
    // Stored transaction ID field; router ID_W must not exceed this
    localparam int ORD_ID_W = 16;
    // Width of each statistics counter
    localparam int CNT_W = 32;

    typedef struct packed {
        logic [CH_SEL_W-1:0] ch_idx;
        logic                err;
        logic                we;
        logic [ORD_ID_W-1:0] id;
    } order_entry_t;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 0;
    endfunction

endpackage

// File: rtl/mem_router_order_fifo.sv
// In-order response tracking FIFO for the memory channel router.
// Registered storage, full/empty flags, simultaneous push and pop.
module mem_router_order_fifo #(
    parameter int  DEPTH = 8,
    parameter type T     = logic
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     din,
    input  logic pop,
    output T     dout,
    output logic full,
    output logic empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy tracking, wrapping at DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            if (do_push & ~do_pop)
                count <= count + 1'b1;
            else if (do_pop & ~do_push)
                count <= count - 1'b1;
        end
    end

    // Entry storage; contents are only meaningful between push and pop
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mem_channel_router.sv
// Address-interleaved router from one request port to NUM_CH channels.
// Optional MEM_ROUTER_STATS_EN adds per-channel request/stall counters.
module mem_channel_router
    import mem_router_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int ADDR_W          = 34,
    parameter int DATA_W          = 256,
    parameter int ID_W            = 6,
    parameter int INTERLEAVE_LOG2 = 12,
    parameter int CH_ADDR_W       = 28,
    parameter int MAX_OUT         = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic [DATA_W-1:0]           req_wdata,
    input  logic [DATA_W/8-1:0]         req_wstrb,
    input  logic [ID_W-1:0]             req_id,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic [ID_W-1:0]             rsp_id,
    output logic                        rsp_err,
    output logic [NUM_CH-1:0]           ch_req_valid,
    input  logic [NUM_CH-1:0]           ch_req_ready,
    output logic [NUM_CH-1:0]           ch_req_we,
    output logic [NUM_CH*CH_ADDR_W-1:0] ch_req_addr,
    output logic [NUM_CH*DATA_W-1:0]    ch_req_wdata,
    output logic [NUM_CH*DATA_W/8-1:0]  ch_req_wstrb,
    input  logic [NUM_CH-1:0]           ch_rsp_valid,
    output logic [NUM_CH-1:0]           ch_rsp_ready,
`ifdef MEM_ROUTER_STATS_EN
    input  logic [NUM_CH*DATA_W-1:0]    ch_rsp_rdata,
    output logic [NUM_CH*CNT_W-1:0]     stat_req_cnt,
    output logic [NUM_CH*CNT_W-1:0]     stat_stall_cnt
`else
    input  logic [NUM_CH*DATA_W-1:0]    ch_rsp_rdata
`endif
);

    localparam int SEL_W = sel_width(NUM_CH);
    localparam int SW    = (SEL_W > 0) ? SEL_W : 1;
    localparam logic [ADDR_W-1:0] LOW_MASK =
        (ADDR_W'(1) << INTERLEAVE_LOG2) - ADDR_W'(1);

    logic [SW-1:0]        sel;
    logic [ADDR_W-1:0]    upper;
    logic [ADDR_W-1:0]    packed_addr;
    logic [CH_ADDR_W-1:0] local_addr;
    logic                 err;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    order_entry_t         entry;
    order_entry_t         head;
    logic [SW-1:0]        head_ch;

    if (NUM_CH > 1) begin : g_sel
        assign sel = req_addr[INTERLEAVE_LOG2 +: SW];
    end else begin : g_nosel
        assign sel = '0;
    end

    // Drop the channel-select bits and close the gap they leave
    assign upper       = req_addr >> (INTERLEAVE_LOG2 + SEL_W);
    assign packed_addr = (upper << INTERLEAVE_LOG2) | (req_addr & LOW_MASK);
    assign local_addr  = packed_addr[CH_ADDR_W-1:0];
    assign err         = |(req_addr >> (CH_ADDR_W + SEL_W));

    assign req_ready = ~full & (err | ch_req_ready[sel]);
    assign push      = req_valid & req_ready;

    assign entry.ch_idx = CH_SEL_W'(sel);
    assign entry.err    = err;
    assign entry.we     = req_we;
    assign entry.id     = ORD_ID_W'(req_id);

    assign ch_req_we    = {NUM_CH{req_we}};
    assign ch_req_addr  = {NUM_CH{local_addr}};
    assign ch_req_wdata = {NUM_CH{req_wdata}};
    assign ch_req_wstrb = {NUM_CH{req_wstrb}};

    // Only the decoded channel sees a request; decode errors reach none
    always_comb begin
        ch_req_valid = '0;
        if (req_valid & ~err & ~full)
            ch_req_valid[sel] = 1'b1;
    end

    mem_router_order_fifo #(
        .DEPTH (MAX_OUT),
        .T     (order_entry_t)
    ) u_order (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (entry),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign head_ch = head.ch_idx[SW-1:0];
    assign rsp_id  = head.id[ID_W-1:0];
    assign pop     = rsp_valid & rsp_ready;

    // Return responses strictly in request order from the head channel
    always_comb begin
        rsp_valid    = 1'b0;
        rsp_err      = 1'b0;
        rsp_rdata    = '0;
        ch_rsp_ready = '0;
        if (!empty) begin
            if (head.err) begin
                rsp_valid = 1'b1;
                rsp_err   = 1'b1;
            end else begin
                rsp_valid             = ch_rsp_valid[head_ch];
                ch_rsp_ready[head_ch] = rsp_ready;
                if (!head.we)
                    rsp_rdata = ch_rsp_rdata[head_ch*DATA_W +: DATA_W];
            end
        end
    end

`ifdef MEM_ROUTER_STATS_EN
    for (genvar i = 0; i < NUM_CH; i++) begin : g_stat
        logic [CNT_W-1:0] req_cnt;
        logic [CNT_W-1:0] stall_cnt;

        // Saturating per-channel accepted-request and stall counters
        always_ff @(posedge clk) begin
            if (rst) begin
                req_cnt   <= '0;
                stall_cnt <= '0;
            end else begin
                if (ch_req_valid[i] & ch_req_ready[i] & ~&req_cnt)
                    req_cnt <= req_cnt + 1'b1;
                if (ch_req_valid[i] & ~ch_req_ready[i] & ~&stall_cnt)
                    stall_cnt <= stall_cnt + 1'b1;
            end
        end

        assign stat_req_cnt[i*CNT_W +: CNT_W]   = req_cnt;
        assign stat_stall_cnt[i*CNT_W +: CNT_W] = stall_cnt;
    end
`endif

endmodule

// File: tb/tb_mem_channel_router.sv
// Self-checking bench for mem_channel_router with a queue-based model.
// Covers routing, ordering, decode errors, full FIFO, reset, stats.
module tb_mem_channel_router;

    localparam int NUM_CH    = 4;
    localparam int ADDR_W    = 34;
    localparam int DATA_W    = 256;
    localparam int ID_W      = 6;
    localparam int CH_ADDR_W = 28;
    localparam int MAX_OUT   = 8;

    logic                        clk;
    logic                        rst;
    logic                        req_valid;
    logic                        req_ready;
    logic                        req_we;
    logic [ADDR_W-1:0]           req_addr;
    logic [DATA_W-1:0]           req_wdata;
    logic [DATA_W/8-1:0]         req_wstrb;
    logic [ID_W-1:0]             req_id;
    logic                        rsp_valid;
    logic                        rsp_ready;
    logic [DATA_W-1:0]           rsp_rdata;
    logic [ID_W-1:0]             rsp_id;
    logic                        rsp_err;
    logic [NUM_CH-1:0]           ch_req_valid;
    logic [NUM_CH-1:0]           ch_req_ready;
    logic [NUM_CH-1:0]           ch_req_we;
    logic [NUM_CH*CH_ADDR_W-1:0] ch_req_addr;
    logic [NUM_CH*DATA_W-1:0]    ch_req_wdata;
    logic [NUM_CH*DATA_W/8-1:0]  ch_req_wstrb;
    logic [NUM_CH-1:0]           ch_rsp_valid;
    logic [NUM_CH-1:0]           ch_rsp_ready;
    logic [NUM_CH*DATA_W-1:0]    ch_rsp_rdata;
`ifdef MEM_ROUTER_STATS_EN
    logic [NUM_CH*32-1:0]        stat_req_cnt;
    logic [NUM_CH*32-1:0]        stat_stall_cnt;
`endif

    mem_channel_router dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_wstrb      (req_wstrb),
        .req_id         (req_id),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_rdata      (rsp_rdata),
        .rsp_id         (rsp_id),
        .rsp_err        (rsp_err),
        .ch_req_valid   (ch_req_valid),
        .ch_req_ready   (ch_req_ready),
        .ch_req_we      (ch_req_we),
        .ch_req_addr    (ch_req_addr),
        .ch_req_wdata   (ch_req_wdata),
        .ch_req_wstrb   (ch_req_wstrb),
        .ch_rsp_valid   (ch_rsp_valid),
        .ch_rsp_ready   (ch_rsp_ready),
`ifdef MEM_ROUTER_STATS_EN
        .ch_rsp_rdata   (ch_rsp_rdata),
        .stat_req_cnt   (stat_req_cnt),
        .stat_stall_cnt (stat_stall_cnt)
`else
        .ch_rsp_rdata   (ch_rsp_rdata)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [ID_W-1:0]   id;
        logic              err;
        logic [DATA_W-1:0] rdata;
        int                ch;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] ch_q[NUM_CH][$];
    logic [ID_W-1:0]   got_ids[$];
    int unsigned       m_req[NUM_CH];
    int unsigned       m_stall[NUM_CH];
    int                checks = 0;
    int                errors = 0;
    logic              late = 1'b0;

    logic [NUM_CH-1:0]    last_chv;
    logic [NUM_CH-1:0]    last_crr;
    logic [CH_ADDR_W-1:0] last_local;
    logic                 last_rdy;
    logic                 last_rv;

    task automatic check(input string tag,
                         input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_sel(input logic [ADDR_W-1:0] a);
        longint unsigned v = 64'(a);
        return int'((v / 4096) % NUM_CH);
    endfunction

    function automatic logic [CH_ADDR_W-1:0] m_local(input logic [ADDR_W-1:0] a);
        longint unsigned v = 64'(a);
        longint unsigned l = (v / (4096 * NUM_CH)) * 4096 + (v % 4096);
        return CH_ADDR_W'(l % (64'd1 << CH_ADDR_W));
    endfunction

    function automatic logic m_err(input logic [ADDR_W-1:0] a);
        longint unsigned v = 64'(a);
        return v >= (64'd1 << (CH_ADDR_W + 2));
    endfunction

    task automatic cyc(input logic r, input logic rv, input logic we,
                       input logic [ADDR_W-1:0] a, input logic [ID_W-1:0] id,
                       input logic [NUM_CH-1:0] rdy, input logic [NUM_CH-1:0] en,
                       input logic rr);
        logic [DATA_W-1:0] newd;
        logic [NUM_CH-1:0] drv;
        logic [NUM_CH-1:0] exp_chv;
        logic [NUM_CH-1:0] exp_crr;
        logic              exp_rdy;
        logic              exp_rv;
        logic              e;
        logic              full;
        int                s;
        exp_t              h;
        exp_t              n;
        rst          = r;
        req_valid    = rv;
        req_we       = we;
        req_addr     = a;
        req_wdata    = {8{$urandom}};
        req_wstrb    = {$urandom};
        req_id       = id;
        ch_req_ready = rdy;
        rsp_ready    = rr;
        drv          = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_rsp_rdata[c*DATA_W +: DATA_W] = {8{$urandom}};
            if (late) begin
                drv[c] = 1'b1;
            end else if (en[c] && ch_q[c].size() > 0) begin
                drv[c] = 1'b1;
                ch_rsp_rdata[c*DATA_W +: DATA_W] = ch_q[c][0];
            end
        end
        ch_rsp_valid = drv;
        #1;
        s       = m_sel(a);
        e       = m_err(a);
        full    = exp_q.size() >= MAX_OUT;
        exp_rdy = !full && (e || rdy[s]);
        exp_chv = (rv && !e && !full) ? NUM_CH'(1 << s) : '0;
        exp_rv  = 1'b0;
        exp_crr = '0;
        h       = '{default: '0};
        if (exp_q.size() > 0) begin
            h = exp_q[0];
            if (h.err) begin
                exp_rv = 1'b1;
            end else begin
                exp_rv = drv[h.ch];
                if (rr)
                    exp_crr[h.ch] = 1'b1;
            end
        end
        last_chv   = ch_req_valid;
        last_crr   = ch_rsp_ready;
        last_rdy   = req_ready;
        last_rv    = rsp_valid;
        last_local = ch_req_addr[s*CH_ADDR_W +: CH_ADDR_W];
        if (!r) begin
            check("req_ready", req_ready, exp_rdy);
            check("ch_req_valid", ch_req_valid, exp_chv);
            if (exp_chv != 0) begin
                check("ch_req_addr", last_local, m_local(a));
                check("ch_req_we", ch_req_we[s], we);
                check("ch_req_wdata", ch_req_wdata[s*DATA_W +: DATA_W], req_wdata);
            end
            check("rsp_valid", rsp_valid, exp_rv);
            check("ch_rsp_ready", ch_rsp_ready, exp_crr);
            if (exp_rv) begin
                check("rsp_id", rsp_id, h.id);
                check("rsp_err", rsp_err, h.err);
                check("rsp_rdata", rsp_rdata, h.rdata);
                if (rr)
                    got_ids.push_back(rsp_id);
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (exp_chv[c] && rdy[c])
                    m_req[c]++;
                if (exp_chv[c] && !rdy[c])
                    m_stall[c]++;
            end
        end
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            for (int c = 0; c < NUM_CH; c++) begin
                ch_q[c].delete();
                m_req[c]   = 0;
                m_stall[c] = 0;
            end
        end else begin
            if (exp_rv && rr) begin
                if (!h.err)
                    void'(ch_q[h.ch].pop_front());
                void'(exp_q.pop_front());
            end
            if (rv && exp_rdy) begin
                newd = {8{$urandom}};
                if (!e)
                    ch_q[s].push_back(newd);
                n.id    = id;
                n.err   = e;
                n.rdata = (e || we) ? '0 : newd;
                n.ch    = s;
                exp_q.push_back(n);
            end
        end
        #1;
    endtask

    task automatic idle(input int cycles, input logic [NUM_CH-1:0] en,
                        input logic rr);
        for (int i = 0; i < cycles; i++)
            cyc(1'b0, 1'b0, 1'b0, '0, '0, '1, en, rr);
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr(input logic bad);
        logic [ADDR_W-1:0] a;
        a = {$urandom, $urandom};
        a[ADDR_W-1:CH_ADDR_W+2] = '0;
        if (bad)
            a[CH_ADDR_W + 2 + $urandom_range(0, 3)] = 1'b1;
        return a;
    endfunction

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        req_wstrb    = '0;
        req_id       = '0;
        rsp_ready    = 1'b0;
        ch_req_ready = '0;
        ch_rsp_valid = '0;
        ch_rsp_rdata = '0;

        cyc(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
        idle(1, '0, 1'b1);
        check("reset_rsp_valid", last_rv, 1'b0);
        check("reset_ch_req_valid", last_chv, 4'b0000);

        cyc(1'b0, 1'b1, 1'b1, 34'h0_0000_3010, 6'd3, 4'hF, 4'h0, 1'b0);
        check("wr_onehot", last_chv, 4'b1000);
        check("wr_local", last_local, 28'h000_0010);
        idle(3, 4'hF, 1'b1);

        cyc(1'b0, 1'b1, 1'b0, 34'h1_0000_0000, 6'd9, 4'h0, 4'h0, 1'b0);
        check("err_no_valid", last_chv, 4'b0000);
        check("err_ready", last_rdy, 1'b1);
        idle(2, 4'hF, 1'b1);

        got_ids.delete();
        cyc(1'b0, 1'b1, 1'b0, 34'h0_0000_1000, 6'd5, 4'hF, 4'h0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 34'h0_0000_0000, 6'd6, 4'hF, 4'h0, 1'b0);
        idle(3, 4'b0001, 1'b1);
        check("order_ch0_held", last_crr[0], 1'b0);
        check("order_no_rsp", last_rv, 1'b0);
        idle(3, 4'b0011, 1'b1);
        check("order_count", got_ids.size(), 2);
        if (got_ids.size() == 2) begin
            check("order_first", got_ids[0], 6'd5);
            check("order_second", got_ids[1], 6'd6);
        end

        for (int i = 0; i < MAX_OUT; i++)
            cyc(1'b0, 1'b1, 1'b0, rand_addr(1'b0), ID_W'(i), 4'hF, 4'h0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, rand_addr(1'b0), 6'd40, 4'hF, 4'h0, 1'b0);
        check("full_ready", last_rdy, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, rand_addr(1'b0), 6'd41, 4'hF, 4'hF, 1'b1);
        check("full_pop_ready", last_rdy, 1'b0);
        check("full_pop_rsp", last_rv, 1'b1);
        idle(12, 4'hF, 1'b1);

        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b1, 1'b0, rand_addr(1'b0), ID_W'(20 + i), 4'hF, 4'h0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
        late = 1'b1;
        idle(1, 4'hF, 1'b1);
        check("rst_rsp_valid", last_rv, 1'b0);
        idle(3, 4'hF, 1'b1);
        check("rst_no_forward", last_crr, 4'b0000);
        late = 1'b0;

        for (int i = 0; i < 400; i++) begin
            cyc(1'b0, 1'($urandom), 1'($urandom),
                rand_addr($urandom_range(0, 7) == 0), ID_W'($urandom),
                NUM_CH'($urandom), NUM_CH'($urandom),
                $urandom_range(0, 3) != 0);
        end
        idle(40, 4'hF, 1'b1);

`ifdef MEM_ROUTER_STATS_EN
        cyc(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 34'h0_0000_2000, 6'd1, 4'b1011, 4'h0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 34'h0_0000_2040, 6'd1, 4'b1011, 4'h0, 1'b0);
        for (int i = 0; i < 5; i++)
            cyc(1'b0, 1'b1, 1'b0, 34'h0_0000_2000 + 34'(i * 64), ID_W'(i),
                4'hF, 4'h0, 1'b0);
        idle(10, 4'hF, 1'b1);
        check("stat_req_ch2", stat_req_cnt[2*32 +: 32], 32'd5);
        check("stat_stall_ch2", stat_stall_cnt[2*32 +: 32], 32'd2);
        for (int c = 0; c < NUM_CH; c++) begin
            check("stat_req_model", stat_req_cnt[c*32 +: 32], m_req[c]);
            check("stat_stall_model", stat_stall_cnt[c*32 +: 32], m_stall[c]);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_channel_router.md
MEM_CHANNEL_ROUTER -- requirements
Module: mem_channel_router

Interface
REQ-001 SHALL have parameters, one per line:
- NUM_CH, 4: memory channels; power of two, 1..8.
- ADDR_W, 34: request address width.
- DATA_W, 256: data width.
- ID_W, 6: transaction ID width.
- INTERLEAVE_LOG2, 12: log2 of the interleave granule in bytes.
- CH_ADDR_W, 28: local address width per channel.
- MAX_OUT, 8: outstanding transactions; power of two.
REQ-002 SHALL use one clock and a synchronous, active-high reset; ports are named clk and rst.
REQ-003 SHALL have ports, one per line:
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- req_valid / req_ready, in / out, 1 / 1: upstream request handshake.
- req_we, in, 1: 1 = write, 0 = read.
- req_addr, in, ADDR_W: byte address.
- req_wdata, in, DATA_W: write data.
- req_wstrb, in, DATA_W/8: write byte strobes.
- req_id, in, ID_W: transaction ID.
- rsp_valid / rsp_ready, out / in, 1 / 1: upstream response handshake.
- rsp_rdata, out, DATA_W: read data.
- rsp_id, out, ID_W: transaction ID.
- rsp_err, out, 1: decode error.
- ch_req_valid / ch_req_ready, out / in, NUM_CH each: per-channel request handshake.
- ch_req_we, out, NUM_CH: per-channel write flag.
- ch_req_addr, out, NUM_CH*CH_ADDR_W: per-channel local address.
- ch_req_wdata, out, NUM_CH*DATA_W: per-channel write data.
- ch_req_wstrb, out, NUM_CH*DATA_W/8: per-channel write strobes.
- ch_rsp_valid / ch_rsp_ready, in / out, NUM_CH each: per-channel response handshake.
- ch_rsp_rdata, in, NUM_CH*DATA_W: per-channel read data.

Function
REQ-004 SHALL select the channel as sel = req_addr[INTERLEAVE_LOG2 +: log2(NUM_CH)] (sel = 0 when NUM_CH = 1).
REQ-005 SHALL form the local address by removing the sel bits and taking the low CH_ADDR_W bits of {upper bits, req_addr[INTERLEAVE_LOG2-1:0]}.
REQ-006 SHALL flag a decode error when any req_addr bit at or above CH_ADDR_W + log2(NUM_CH) is set.
REQ-007 SHALL assert ch_req_valid[sel] = req_valid & !err & !order_full; every other ch_req_valid bit is 0; the request path is zero-latency and combinational.
REQ-008 SHALL drive req_ready = !order_full & (err | ch_req_ready[sel]).
REQ-009 SHALL, on each accepted request (req_valid & req_ready), push {sel, err, req_id} into an in-order FIFO of depth MAX_OUT.
REQ-010 SHALL drive the FIFO head to the upstream response:
- error entry: rsp_valid = 1, rsp_err = 1, rsp_rdata = 0, no channel involved.
- normal entry: rsp_valid = ch_rsp_valid[head.ch], rsp_rdata from that channel, ch_rsp_ready[head.ch] = rsp_ready.
REQ-011 SHALL hold ch_rsp_ready at 0 for all non-head channels, so out-of-order channel responses stall until their turn.
REQ-012 SHALL drive rsp_id from the stored ID, and pop the FIFO on rsp_valid & rsp_ready.
REQ-013 SHALL keep req_ready at 0 when the FIFO is full, even if a pop occurs in the same cycle.
REQ-014 SHALL allow a push and a pop in the same cycle when the FIFO is neither full nor empty, leaving the count unchanged.
REQ-015 SHALL drive rsp_valid = 0 when the FIFO is empty.
REQ-016 SHALL return one response per request for writes as well as reads; for writes rsp_rdata is don't-care and is driven 0.

Reset
REQ-017 SHALL, while rst = 1 at a clk edge, empty the FIFO (pointers and count = 0), clear stats counters, and drive rsp_valid = 0 and all ch_req_valid = 0 on the next cycle.
REQ-018 SHALL discard outstanding transactions on reset mid-operation; channels are reset by the same rst, and no response for a pre-reset request appears after reset.

Configuration
REQ-019 SHALL, when MEM_ROUTER_STATS_EN is defined, add ports:
- stat_req_cnt, out, NUM_CH*32: per-channel accepted-request count.
- stat_stall_cnt, out, NUM_CH*32: cycles with ch_req_valid & !ch_req_ready.
REQ-020 SHALL make both stats counters saturate at 0xFFFF_FFFF.
REQ-021 SHALL, when MEM_ROUTER_STATS_EN is not defined, omit these ports and counters; routing behaviour is identical either way.

Structure
REQ-022 SHALL place the order-entry struct typedef (ch_idx, err, id), the CH_SEL_W helper constant, and the counter width in package mem_router_pkg.
REQ-023 SHALL implement the order FIFO as sub-module mem_router_order_fifo (parametrised depth and entry type, full/empty flags, registered storage).

Verification (NUM_CH=4, INTERLEAVE_LOG2=12, CH_ADDR_W=28, MAX_OUT=8)
REQ-024 SHALL cover: write to 0x0_0000_3010 -> ch_req_valid = 4'b1000, local addr 0x000_0010, then one response with rsp_err = 0.
REQ-025 SHALL cover: read ID 5 to 0x1000, then ID 6 to 0x0000; ch0 responds first -> ch_rsp_ready[0] held 0 until ID 5 returns from ch1; rsp order is 5 then 6.
REQ-026 SHALL cover: read to 0x1_0000_0000 -> no ch_req_valid, req_ready = 1, response rsp_err = 1, rsp_rdata = 0, ID preserved.
REQ-027 SHALL cover: 8 reads with channel responses withheld -> 9th request sees req_ready = 0, including in the cycle of the first pop.
REQ-028 SHALL cover: rst pulsed with 3 outstanding -> next cycle rsp_valid = 0; late channel responses are never forwarded.
REQ-029 SHALL cover, with MEM_ROUTER_STATS_EN: 5 accepted requests to ch2 with 2 stall cycles -> stat_req_cnt[2] = 5, stat_stall_cnt[2] = 2.
